// File: rtl/pos_cell_reader.sv
// Sweeps a cell position memory: reads the particle count at address 0, then
// streams addresses 1..N through a 4-entry credit-controlled output FIFO.
module pos_cell_reader #(
  parameter int unsigned DATA_WIDTH   = 96,
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter int unsigned PARTICLE_NUM = 220
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] particle_count,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_rden,
  output logic                  mem_wren,
  output logic [DATA_WIDTH-1:0] mem_data,
  input  logic [DATA_WIDTH-1:0] mem_q,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_pos,
  output logic [ADDR_WIDTH-1:0] out_index,
  output logic                  out_last
);

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = 3;
  localparam logic [ADDR_WIDTH-1:0] N_MAX = ADDR_WIDTH'(PARTICLE_NUM - 1);

  typedef enum logic [2:0] {IDLE, RD_CNT, WAIT_CNT, STREAM, DRAIN, FIN} state_t;

  state_t                state;
  logic                  wait_second;
  logic                  v1, v2;
  logic [ADDR_WIDTH-1:0] a1, a2;
  logic [CW-1:0]         count;
  logic [DATA_WIDTH-1:0] pos_q  [DEPTH];
  logic [ADDR_WIDTH-1:0] idx_q  [DEPTH];
  logic                  last_q [DEPTH];

  logic                  push, pop, room, last_rd;
  logic [CW-1:0]         cnt_nxt, wr_idx;
  logic [ADDR_WIDTH-1:0] n_new;

  assign mem_wren  = 1'b0;
  assign mem_data  = '0;
  assign out_pos   = pos_q[0];
  assign out_index = idx_q[0];
  assign out_last  = last_q[0];

  // FIFO bookkeeping and read credit: occupancy after this edge plus reads still in flight
  always_comb begin
    push    = v2;
    pop     = out_valid & out_ready;
    cnt_nxt = count + CW'(push) - CW'(pop);
    wr_idx  = count - CW'(pop);
    room    = (cnt_nxt + CW'(mem_rden) + CW'(v1)) < CW'(DEPTH);
    last_rd = mem_rden && (mem_address == particle_count);
    n_new   = (mem_q[ADDR_WIDTH-1:0] > N_MAX) ? N_MAX : mem_q[ADDR_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      wait_second    <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      particle_count <= '0;
      mem_address    <= '0;
      mem_rden       <= 1'b0;
      v1             <= 1'b0;
      v2             <= 1'b0;
      a1             <= '0;
      a2             <= '0;
      count          <= '0;
      out_valid      <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        pos_q[i]  <= '0;
        idx_q[i]  <= '0;
        last_q[i] <= 1'b0;
      end
    end else begin
      // Two-cycle read latency tracker; only sweep reads are tagged for the FIFO
      v1        <= mem_rden && (state == STREAM);
      a1        <= mem_address;
      v2        <= v1;
      a2        <= a1;
      count     <= cnt_nxt;
      out_valid <= (cnt_nxt != '0);
      done      <= 1'b0;

      // Shift-register FIFO: entry 0 is the head, so outputs come straight from flops
      if (pop) begin
        for (int i = 0; i < 3; i++) begin
          pos_q[i]  <= pos_q[i+1];
          idx_q[i]  <= idx_q[i+1];
          last_q[i] <= last_q[i+1];
        end
      end
      if (push) begin
        for (int i = 0; i < 4; i++) begin
          if (wr_idx == CW'(i)) begin
            pos_q[i]  <= mem_q;
            idx_q[i]  <= a2;
            last_q[i] <= (a2 == particle_count);
          end
        end
      end

      case (state)
        IDLE: begin
          if (start) begin
            state       <= RD_CNT;
            busy        <= 1'b1;
            mem_rden    <= 1'b1;
            mem_address <= '0;
          end
        end
        RD_CNT: begin
          mem_rden    <= 1'b0;
          wait_second <= 1'b0;
          state       <= WAIT_CNT;
        end
        WAIT_CNT: begin
          if (!wait_second) begin
            wait_second <= 1'b1;
          end else begin
            particle_count <= n_new;
            if (n_new == '0) begin
              state <= FIN;
              done  <= 1'b1;
            end else begin
              state       <= STREAM;
              mem_rden    <= 1'b1;
              mem_address <= ADDR_WIDTH'(1);
            end
          end
        end
        STREAM: begin
          if (last_rd) begin
            state    <= DRAIN;
            mem_rden <= 1'b0;
          end else if (room) begin
            mem_rden    <= 1'b1;
            mem_address <= mem_address + ADDR_WIDTH'(1);
          end else begin
            mem_rden <= 1'b0;
          end
        end
        DRAIN: begin
          if (pop && out_last && (count == CW'(1)) && !v1 && !v2) begin
            state <= FIN;
            done  <= 1'b1;
          end
        end
        FIN: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pos_cell_reader.sv
// Bench for pos_cell_reader: memory model with 2-cycle latency, sweep driver,
// and a reference model that derives the expected stream from memory contents.
module tb_pos_cell_reader;

  localparam int unsigned DW = 96;
  localparam int unsigned AW = 8;
  localparam int unsigned PN = 220;

  logic          clk = 1'b0;
  logic          rst, start, busy, done;
  logic [AW-1:0] particle_count, mem_address, out_index;
  logic          mem_rden, mem_wren, out_valid, out_ready, out_last;
  logic [DW-1:0] mem_data, mem_q, out_pos;

  pos_cell_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PARTICLE_NUM(PN)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .particle_count(particle_count), .mem_address(mem_address), .mem_rden(mem_rden),
    .mem_wren(mem_wren), .mem_data(mem_data), .mem_q(mem_q), .out_valid(out_valid),
    .out_ready(out_ready), .out_pos(out_pos), .out_index(out_index), .out_last(out_last)
  );

  always #5 clk = ~clk;

  // Memory model: data appears on mem_q two cycles after its read enable
  logic [DW-1:0] mem [256];
  logic [DW-1:0] q1;
  always @(posedge clk) begin
    q1    <= mem_rden ? mem[mem_address] : '0;
    mem_q <= q1;
  end

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] got_pos [$];
  int            got_idx [$];
  bit            got_last[$];
  int first_valid_k, last_xfer_k, done_k, done_cnt, credit_viol, stab_err, max_idx;
  int busy_low;
  bit timed_out;

  function automatic int exp_n();
    int c;
    c = int'(mem[0][7:0]);
    return (c > int'(PN) - 1) ? int'(PN) - 1 : c;
  endfunction

  // Number of differences between the collected stream and the one memory implies
  function automatic int seq_mismatch();
    int n, e;
    n = exp_n();
    e = 0;
    if (got_idx.size() != n) e++;
    for (int i = 0; i < got_idx.size() && i < n; i++) begin
      if (got_idx[i] != i + 1) e++;
      if (got_pos[i] !== mem[i+1]) e++;
      if (got_last[i] != (i + 1 == n)) e++;
    end
    return e;
  endfunction

  task automatic fill(input int cnt_byte);
    for (int i = 0; i < 256; i++) mem[i] = {$urandom(), $urandom(), $urandom()};
    mem[0][7:0] = 8'(cnt_byte);
  endtask

  // Drives one sweep; ready_mode 0: always ready, 1: 1 on / 2 off, 2: random
  task automatic run_sweep(input int ready_mode, input bit extra_starts, input int abort_after);
    bit            prev_stall, rdy, finished;
    logic [DW-1:0] prev_pos;
    logic [AW-1:0] prev_idx;
    logic          prev_last;
    int            issued;
    got_pos.delete(); got_idx.delete(); got_last.delete();
    first_valid_k = -1; last_xfer_k = -1; done_k = -1; done_cnt = 0;
    credit_viol = 0; stab_err = 0; max_idx = 0; busy_low = 0; issued = 0;
    prev_stall = 0; finished = 0; timed_out = 0;
    prev_pos = '0; prev_idx = '0; prev_last = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int k = 1; k < 3000; k++) begin
      start = extra_starts && (k == 3 || k == 9);
      case (ready_mode)
        0:       rdy = 1'b1;
        1:       rdy = (k % 3 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      out_ready = rdy;
      if (prev_stall && (out_pos !== prev_pos || out_index !== prev_idx || out_last !== prev_last))
        stab_err++;
      if (mem_rden && mem_address != '0) issued++;
      if (issued - got_idx.size() > 4) credit_viol++;
      if (done_k < 0 && !busy) busy_low++;
      if (out_valid && first_valid_k < 0) first_valid_k = k;
      if (out_valid && rdy) begin
        got_pos.push_back(out_pos);
        got_idx.push_back(int'(out_index));
        got_last.push_back(out_last);
        if (int'(out_index) > max_idx) max_idx = int'(out_index);
        last_xfer_k = k;
      end
      prev_stall = out_valid && !rdy;
      prev_pos = out_pos; prev_idx = out_index; prev_last = out_last;
      if (done) begin
        done_cnt++;
        if (done_k < 0) done_k = k;
      end
      if (abort_after > 0 && got_idx.size() == abort_after) begin
        finished = 1;
        break;
      end
      if (done_k >= 0 && k >= done_k + 2) begin
        finished = 1;
        break;
      end
      @(negedge clk);
    end
    start = 1'b0;
    if (!finished) timed_out = 1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    n_tests++; if (particle_count !== '0) begin n_fail++; $display("FAIL reset_pc got %0d want 0", particle_count); end
    n_tests++; if (mem_address !== '0) begin n_fail++; $display("FAIL reset_addr got %0d want 0", mem_address); end
    n_tests++; if (mem_rden !== 1'b0) begin n_fail++; $display("FAIL reset_rden got %b want 0", mem_rden); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", out_valid); end
    n_tests++; if (out_pos !== '0) begin n_fail++; $display("FAIL reset_pos got %h want 0", out_pos); end
    n_tests++; if (out_index !== '0) begin n_fail++; $display("FAIL reset_index got %0d want 0", out_index); end
    n_tests++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL reset_last got %b want 0", out_last); end
    n_tests++; if (mem_wren !== 1'b0 || mem_data !== '0) begin n_fail++; $display("FAIL reset_wr got %b/%h want 0/0", mem_wren, mem_data); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    fill(3);
    for (int i = 1; i <= 3; i++) mem[i][7:0] = 8'(i);
    run_sweep(0, 0, 0);
    n_tests++; if (timed_out) begin n_fail++; $display("FAIL basic_timeout got 1 want 0"); end
    n_tests++; if (got_idx.size() != 3) begin n_fail++; $display("FAIL basic_count got %0d want 3", got_idx.size()); end
    n_tests++; if (seq_mismatch() != 0) begin n_fail++; $display("FAIL basic_seq got %0d diffs want 0", seq_mismatch()); end
    n_tests++; if (first_valid_k != 7) begin n_fail++; $display("FAIL basic_latency got %0d want 7", first_valid_k); end
    n_tests++; if (done_k != last_xfer_k + 1) begin n_fail++; $display("FAIL basic_done_cycle got %0d want %0d", done_k, last_xfer_k + 1); end
    n_tests++; if (done_cnt != 1) begin n_fail++; $display("FAIL basic_done_pulses got %0d want 1", done_cnt); end
    n_tests++; if (particle_count !== 8'd3) begin n_fail++; $display("FAIL basic_pc got %0d want 3", particle_count); end
    n_tests++; if (busy_low != 0) begin n_fail++; $display("FAIL basic_busy_gap got %0d want 0", busy_low); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_end got %b want 0", busy); end
  endtask

  task automatic test_zero();
    fill(0);
    run_sweep(0, 0, 0);
    n_tests++; if (timed_out) begin n_fail++; $display("FAIL zero_timeout got 1 want 0"); end
    n_tests++; if (first_valid_k != -1) begin n_fail++; $display("FAIL zero_valid got cycle %0d want none", first_valid_k); end
    n_tests++; if (done_cnt != 1) begin n_fail++; $display("FAIL zero_done got %0d want 1", done_cnt); end
    n_tests++; if (particle_count !== '0) begin n_fail++; $display("FAIL zero_pc got %0d want 0", particle_count); end
  endtask

  task automatic test_stall();
    fill(10);
    run_sweep(1, 0, 0);
    n_tests++; if (timed_out) begin n_fail++; $display("FAIL stall_timeout got 1 want 0"); end
    n_tests++; if (seq_mismatch() != 0) begin n_fail++; $display("FAIL stall_seq got %0d diffs want 0", seq_mismatch()); end
    n_tests++; if (credit_viol != 0) begin n_fail++; $display("FAIL stall_credit got %0d want 0", credit_viol); end
    n_tests++; if (stab_err != 0) begin n_fail++; $display("FAIL stall_stable got %0d want 0", stab_err); end
    n_tests++; if (done_k != last_xfer_k + 1) begin n_fail++; $display("FAIL stall_done_cycle got %0d want %0d", done_k, last_xfer_k + 1); end
  endtask

  task automatic test_clamp();
    fill(255);
    run_sweep(0, 0, 0);
    n_tests++; if (timed_out) begin n_fail++; $display("FAIL clamp_timeout got 1 want 0"); end
    n_tests++; if (particle_count !== 8'd219) begin n_fail++; $display("FAIL clamp_pc got %0d want 219", particle_count); end
    n_tests++; if (max_idx != 219) begin n_fail++; $display("FAIL clamp_max_idx got %0d want 219", max_idx); end
    n_tests++; if (seq_mismatch() != 0) begin n_fail++; $display("FAIL clamp_seq got %0d diffs want 0", seq_mismatch()); end
  endtask

  task automatic test_reset_mid();
    int spurious;
    fill(40);
    run_sweep(0, 0, 5);
    rst = 1'b1;
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0 || out_valid !== 1'b0 || mem_rden !== 1'b0 ||
        mem_address !== '0 || particle_count !== '0 || out_pos !== '0 || out_index !== '0 ||
        out_last !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_outputs got busy=%b valid=%b rden=%b addr=%0d pc=%0d idx=%0d want all 0",
               busy, out_valid, mem_rden, mem_address, particle_count, out_index);
    end
    rst = 1'b0; out_ready = 1'b1;
    spurious = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid || busy || mem_rden) spurious++;
    end
    n_tests++; if (spurious != 0) begin n_fail++; $display("FAIL midrst_spurious got %0d want 0", spurious); end
    fill(12);
    run_sweep(0, 0, 0);
    n_tests++; if (timed_out) begin n_fail++; $display("FAIL midrst_timeout got 1 want 0"); end
    n_tests++; if (seq_mismatch() != 0) begin n_fail++; $display("FAIL midrst_seq got %0d diffs want 0", seq_mismatch()); end
  endtask

  task automatic test_start_busy();
    fill(6);
    run_sweep(0, 1, 0);
    n_tests++; if (timed_out) begin n_fail++; $display("FAIL busystart_timeout got 1 want 0"); end
    n_tests++; if (seq_mismatch() != 0) begin n_fail++; $display("FAIL busystart_seq got %0d diffs want 0", seq_mismatch()); end
    n_tests++; if (done_cnt != 1) begin n_fail++; $display("FAIL busystart_done got %0d want 1", done_cnt); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL busystart_idle got %b want 0", busy); end
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      fill(int'($urandom_range(1, 30)));
      run_sweep(2, 0, 0);
      n_tests++; if (timed_out) begin n_fail++; $display("FAIL rand%0d_timeout got 1 want 0", r); end
      n_tests++; if (seq_mismatch() != 0) begin n_fail++; $display("FAIL rand%0d_seq got %0d diffs want 0", r, seq_mismatch()); end
      n_tests++; if (credit_viol != 0 || stab_err != 0) begin n_fail++; $display("FAIL rand%0d_flow got credit=%0d stable=%0d want 0/0", r, credit_viol, stab_err); end
      n_tests++; if (particle_count !== 8'(exp_n())) begin n_fail++; $display("FAIL rand%0d_pc got %0d want %0d", r, particle_count, exp_n()); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_stall();
    test_clamp();
    test_reset_mid();
    test_start_busy();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pos_cell_reader.md
POS_CELL_READER -- requirements
Module: pos_cell_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 96, meaning the cell word width {posz, posy, posx}, 32 bits each.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, meaning the cell memory address width.
REQ-003 SHALL have parameter PARTICLE_NUM, default 220, meaning the cell memory depth in words, including address 0.
REQ-004 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port start  input  1  one-cycle pulse that begins a cell read sweep.
REQ-007 SHALL have port busy  output  1  high from the cycle after an accepted start until done.
REQ-008 SHALL have port done  output  1  one-cycle pulse when the sweep completes.
REQ-009 SHALL have port particle_count  output  ADDR_WIDTH  particle count latched from address 0.
REQ-010 SHALL have port mem_address  output  ADDR_WIDTH  cell memory address.
REQ-011 SHALL have port mem_rden  output  1  cell memory read enable.
REQ-012 SHALL have port mem_wren  output  1  cell memory write enable; constant 0.
REQ-013 SHALL have port mem_data  output  DATA_WIDTH  cell memory write data; constant 0.
REQ-014 SHALL have port mem_q  input  DATA_WIDTH  cell memory read data; valid 2 cycles after the matching mem_rden.
REQ-015 SHALL have port out_valid  output  1  out_pos, out_index and out_last are valid.
REQ-016 SHALL have port out_ready  input  1  downstream accepts the output; a transfer occurs when out_valid and out_ready are both 1.
REQ-017 SHALL have port out_pos  output  DATA_WIDTH  particle position word.
REQ-018 SHALL have port out_index  output  ADDR_WIDTH  memory address of the emitted particle, range 1..N.
REQ-019 SHALL have port out_last  output  1  marks the final particle of the sweep.

Function
REQ-020 SHALL implement FSM states IDLE, RD_CNT, WAIT_CNT, STREAM, DRAIN, FIN.
REQ-021 In IDLE, start=1 SHALL move the FSM to RD_CNT; start SHALL be ignored in every other state.
REQ-022 RD_CNT SHALL drive mem_rden=1 and mem_address=0 for exactly one cycle, then move to WAIT_CNT.
REQ-023 WAIT_CNT SHALL last 2 cycles; on the second cycle it SHALL latch N = min(mem_q[ADDR_WIDTH-1:0], PARTICLE_NUM-1) into particle_count.
REQ-024 After WAIT_CNT, the FSM SHALL go to FIN if N=0 and to STREAM otherwise.
REQ-025 In STREAM, the block SHALL issue reads at addresses 1..N in ascending order, at most one per cycle.
REQ-026 A read SHALL be issued only when (output FIFO occupancy + reads in flight) < 4.
REQ-027 The block SHALL contain a 4-entry output FIFO; each mem_q SHALL be captured into it exactly 2 cycles after its mem_rden, tagged with its address.
REQ-028 The FIFO SHALL never overflow and SHALL never drop or reorder words.
REQ-029 Once address N has been issued, the FSM SHALL move to DRAIN.
REQ-030 DRAIN SHALL move to FIN when the FIFO is empty, no reads are in flight, and the final transfer has completed.
REQ-031 FIN SHALL pulse done=1 for one cycle and then return to IDLE.
REQ-032 out_valid SHALL equal "FIFO not empty"; out_pos and out_index SHALL come from the FIFO head.
REQ-033 out_last SHALL be 1 only when out_index = N.
REQ-034 While out_valid=1 and out_ready=0, out_pos, out_index and out_last SHALL hold stable.
REQ-035 When a FIFO push and a pop occur in the same cycle, occupancy SHALL be unchanged.
REQ-036 With out_ready held at 1, the block SHALL sustain 1 particle per cycle; the first out_valid SHALL assert 7 cycles after start.
REQ-037 When mem_rden=0, mem_address SHALL hold its last value.
REQ-038 particle_count SHALL hold its value until the next WAIT_CNT latch.

Reset
REQ-039 On rst=1, all state SHALL clear: FSM to IDLE, FIFO emptied, in-flight tracking cleared.
REQ-040 On rst=1, outputs SHALL reset to busy=0, done=0, particle_count=0, mem_address=0, mem_rden=0, out_valid=0, out_pos=0, out_index=0, out_last=0.
REQ-041 Reset asserted mid-sweep SHALL take effect on the next edge; read data still returning afterwards SHALL be discarded.

Verification
REQ-042 Bench SHALL cover: address 0 = 3, words A1..A3 = 0x..01/02/03, out_ready=1 -> three transfers with index 1,2,3, out_last on index 3 only, done exactly 1 cycle after the last transfer.
REQ-043 Bench SHALL cover: count = 0 -> no out_valid, done pulses, particle_count=0.
REQ-044 Bench SHALL cover: count = 10 with out_ready toggling 1-cycle on / 2-cycle off -> all 10 words in order, none lost or duplicated, in-flight+occupancy never > 4, outputs stable while stalled.
REQ-045 Bench SHALL cover: count = 255 with PARTICLE_NUM=220 -> particle_count=219, highest index 219.
REQ-046 Bench SHALL cover: rst asserted during STREAM after 5 transfers -> next cycle all outputs at reset values, no spurious out_valid; a following start completes a normal sweep.
REQ-047 Bench SHALL cover: start pulsed while busy -> ignored; sweep result unchanged.
